// File: rtl/seven_seg_mux_driver.sv
// Two-digit multiplexed 7-segment driver: one-entry handshake buffer, frame-aligned
// digit update, blanking gaps between digits, registered segment/select outputs.
module seven_seg_mux_driver #(
  parameter int REFRESH_CYCLES = 4096,
  parameter int BLANK_CYCLES   = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] msd_i,
  input  logic [3:0] lsd_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       blank_lz_i,
  output logic [6:0] seg_o,
  output logic       sel_o,
  output logic       frame_o,
  output logic [1:0] dbg_state_o
);

  // Handshake: a pair transfers on any cycle where valid_i && ready_o are both high;
  // valid_i may be held or dropped freely, ready_o depends only on internal state.

  localparam int MAX_DWELL = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW        = $clog2(MAX_DWELL + 1);
  localparam logic [CW-1:0] R_LOAD = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] B_LOAD = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    SHOW_M  = 2'd0,
    BLANK_M = 2'd1,
    SHOW_L  = 2'd2,
    BLANK_L = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [3:0]    disp_msd_q, disp_msd_d, disp_lsd_q, disp_lsd_d;
  logic [3:0]    pend_msd_q, pend_msd_d, pend_lsd_q, pend_lsd_d;
  logic          pend_full_q, pend_full_d;
  logic          bnd_q, bnd_d;
  logic [6:0]    seg_q, seg_d;
  logic          sel_q, sel_d;
  logic          frame_q, frame_d;
  logic          dwell_done, boundary, accept;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = 1'b1;
    disp_msd_d  = disp_msd_q;
    disp_lsd_d  = disp_lsd_q;
    pend_msd_d  = pend_msd_q;
    pend_lsd_d  = pend_lsd_q;
    pend_full_d = pend_full_q;
    seg_d       = '0;
    sel_d       = 1'b1;

    dwell_done = (cnt_q == '0);
    boundary   = run_q && (state_q == BLANK_L) && dwell_done;
    accept     = valid_i && !pend_full_q;
    bnd_d      = boundary;
    frame_d    = bnd_q;

    // The first edge after reset release only arms run_q, so SHOW_M spans R full cycles.
    if (run_q) begin
      if (dwell_done) begin
        case (state_q)
          SHOW_M:  begin state_d = BLANK_M; cnt_d = B_LOAD; end
          BLANK_M: begin state_d = SHOW_L;  cnt_d = R_LOAD; end
          SHOW_L:  begin state_d = BLANK_L; cnt_d = B_LOAD; end
          default: begin state_d = SHOW_M;  cnt_d = R_LOAD; end
        endcase
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    if (boundary && pend_full_q) begin
      disp_msd_d  = pend_msd_q;
      disp_lsd_d  = pend_lsd_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_msd_d  = msd_i;
      pend_lsd_d  = lsd_i;
      pend_full_d = 1'b1;
    end

    if (run_q) begin
      case (state_q)
        SHOW_M:  begin
          seg_d = (blank_lz_i && disp_msd_q == 4'h0) ? 7'd0 : decode(disp_msd_q);
          sel_d = 1'b1;
        end
        BLANK_M: sel_d = 1'b1;
        SHOW_L:  begin seg_d = decode(disp_lsd_q); sel_d = 1'b0; end
        default: sel_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SHOW_M;
      cnt_q       <= R_LOAD;
      run_q       <= 1'b0;
      disp_msd_q  <= '0;
      disp_lsd_q  <= '0;
      pend_msd_q  <= '0;
      pend_lsd_q  <= '0;
      pend_full_q <= 1'b0;
      bnd_q       <= 1'b0;
      seg_q       <= '0;
      sel_q       <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      disp_msd_q  <= disp_msd_d;
      disp_lsd_q  <= disp_lsd_d;
      pend_msd_q  <= pend_msd_d;
      pend_lsd_q  <= pend_lsd_d;
      pend_full_q <= pend_full_d;
      bnd_q       <= bnd_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
    end
  end

  assign ready_o     = !pend_full_q;
  assign seg_o       = seg_q;
  assign sel_o       = sel_q;
  assign frame_o     = frame_q;
  assign dbg_state_o = state_q;

endmodule
